// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEL_W   = 3;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Digit write port: one strobe writes one hex digit into the display buffer.
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic               wr_en;
  logic [SEL_W-1:0]   wr_addr;
  logic [DIGIT_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low segment pattern decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] hex,
  output logic [6:0]         pattern
);

  assign pattern = SEG_LUT[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Each digit slot opens with a blanking gap to suppress ghosting.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int NUM_DIGITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  seg7_scan_ctrl_if.slave       wr,
  output logic [DIGIT_W-1:0]    num,
  output logic [SEL_W-1:0]      sel,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

  logic [DIGIT_W-1:0] digit [NUM_DIGITS];
  logic [DIGIT_W-1:0] cur_digit;
  logic [6:0]         pattern;
  scan_state_t        state;
  logic [CNT_W-1:0]   cnt;

  function automatic logic [NUM_DIGITS-1:0] anode_low(input logic [SEL_W-1:0] idx);
    return ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
  endfunction

  // NOTE: the digit buffer is a handful of flops, not a RAM, so it takes a
  // reset like any other state; the display must come up showing zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
    end else if (wr.wr_en) begin
      digit[wr.wr_addr] <= wr.wr_data;
    end
  end

  assign cur_digit = digit[sel];

  seg7_hex_decode u_hex_decode (
    .hex     (cur_digit),
    .pattern (pattern)
  );

  // Refreshed every cycle so a write to the shown digit lands mid-slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num <= '0;
      seg <= 7'h7F;
    end else begin
      num <= cur_digit;
      seg <= pattern;
    end
  end

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every branch reads the pre-edge values of cnt, sel and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      sel        <= '0;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!en) begin
        an <= '1;
      end else begin
        unique case (state)
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_LAST) begin
              state <= SHOW;
              an    <= anode_low(sel);
            end else begin
              an <= '1;
            end
          end
          SHOW: begin
            if (cnt == CNT_LAST) begin
              cnt        <= '0;
              sel        <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
              state      <= BLANK;
              an         <= '1;
              frame_tick <= (sel == SEL_LAST);
            end else begin
              cnt <= cnt + 1'b1;
              an  <= anode_low(sel);
            end
          end
          default: state <= BLANK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with CLK_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int SLOTS   = 8;
  localparam int FRAME   = CLK_DIV * SLOTS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] num;
  logic [2:0] sel;
  logic [6:0] seg;
  logic [7:0] an;
  logic       frame_tick;

  seg7_scan_ctrl_if wr_bus ();

  seg7_scan_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK),
    .NUM_DIGITS   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr         (wr_bus.slave),
    .num        (num),
    .sel        (sel),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int         n_checks = 0;
  int         n_fail   = 0;
  int         k        = 0;
  int         ft_seen  = 0;
  logic [3:0] model [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, got, exp, $time, k);
    end
  endtask

  task automatic write_digit(input logic [2:0] addr, input logic [3:0] data);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = addr;
    wr_bus.wr_data = data;
    model[addr]    = data;
  endtask

  // Advance n enabled clocks; optionally compare against the slot model.
  task automatic advance(input int n, input bit chk);
    int cnt_e, slot_e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      if (frame_tick === 1'b1) ft_seen++;
      if (chk) begin
        cnt_e  = k % CLK_DIV;
        slot_e = (k / CLK_DIV) % SLOTS;
        check("sel", 32'(sel), 32'(slot_e));
        check("an", 32'(an), (cnt_e >= BLANK) ? 32'(8'(~(8'h01 << slot_e))) : 32'hFF);
        check("frame_tick", 32'(frame_tick), (k % FRAME == 0) ? 32'd1 : 32'd0);
        if (cnt_e >= BLANK) begin
          check("seg", 32'(seg), 32'(seg_tab[model[slot_e]]));
          check("num", 32'(num), 32'(model[slot_e]));
        end
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    en             = 1'b0;
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;
    for (int i = 0; i < 8; i++) model[i] = 4'h0;

    // Reset held across several clock edges
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_num", 32'(num), 32'h0);
    check("rst_ft", 32'(frame_tick), 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      write_digit(3'(i), 4'(i + 1));
    end
    @(negedge clk);
    wr_bus.wr_en = 1'b0;
    @(negedge clk);
    check("idle_an", 32'(an), 32'hFF);
    check("idle_sel", 32'(sel), 32'h0);

    // Two full frames
    en = 1'b1;
    k  = 0;
    advance(2 * FRAME, 1'b1);
    check("ft_count_2frames", 32'(ft_seen), 32'd2);

    // Live write to the digit currently shown (slot 3, mid-SHOW)
    advance(3 * CLK_DIV + 4, 1'b1);
    check("live_pre_sel", 32'(sel), 32'd3);
    write_digit(3'd3, 4'hA);
    advance(1, 1'b0);
    wr_bus.wr_en = 1'b0;
    advance(1, 1'b0);
    check("live_seg", 32'(seg), 32'h08);
    check("live_num", 32'(num), 32'hA);
    check("live_an", 32'(an), 32'hF7);
    advance(74, 1'b1);

    // Enable gating mid-SHOW on slot 5
    advance(68, 1'b1);
    check("gate_pre_sel", 32'(sel), 32'd5);
    check("gate_pre_an", 32'(an), 32'hDF);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("gate_an", 32'(an), 32'hFF);
      check("gate_sel", 32'(sel), 32'd5);
      check("gate_ft", 32'(frame_tick), 32'd0);
    end
    en = 1'b1;
    advance(4, 1'b1);
    check("gate_next_sel", 32'(sel), 32'd6);
    advance(16, 1'b1);

    // All-hex sweep on digit 0, one value per frame
    for (int v = 0; v < 16; v++) begin
      write_digit(3'd0, 4'(v));
      advance(1, 1'b1);
      wr_bus.wr_en = 1'b0;
      advance(3, 1'b1);
      check("sweep_seg", 32'(seg), 32'(seg_tab[v]));
      advance(FRAME - 4, 1'b1);
    end

    // Asynchronous reset in the middle of a SHOW phase
    advance(4, 1'b1);
    check("arst_pre_an", 32'(an), 32'hFE);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'hFF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_sel", 32'(sel), 32'h0);
    check("arst_num", 32'(num), 32'h0);
    check("arst_ft", 32'(frame_tick), 32'h0);
    for (int i = 0; i < 8; i++) model[i] = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    advance(CLK_DIV + 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for an 8-digit, common-anode seven-segment display.
- Holds eight 4-bit hex digits written over a simple write port.
- Steps the digit select through 0..7, decodes the current digit to active-low segments and drives one active-low anode enable at a time.
- Inserts a blanking gap between digits to suppress ghosting; this is the sequential driver that sits in front of the display decoder.

Parameters:
- CLK_DIV, 1000, clock cycles per digit slot (blank plus show); must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must be at least 1.
- NUM_DIGITS, 8, number of digits scanned; fixed at 8 for this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- en  input  1  scan enable; 0 blanks the display and freezes the scan.
- wr_en  input  1  digit write strobe, one cycle.
- wr_addr  input  3  digit index written.
- wr_data  input  4  hex value written.
- num  output  4  registered hex value of the current digit.
- sel  output  3  current digit index.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  8  anode enables, active-low, one-hot-low while showing.
- frame_tick  output  1  one-cycle pulse at the end of digit 7's slot.

Behaviour:
- Reset (rst_n=0, asynchronous), all values held until release:
  - digit registers 4'h0; sel 0; num 0.
  - seg 7'h7F; an 8'hFF; frame_tick 0.
  - state BLANK; slot counter 0.
- State machine, advanced only while en=1:
  - BLANK: an=8'hFF. Counter runs 0..BLANK_CYCLES-1, then moves to SHOW and the counter continues.
  - SHOW: an[sel]=0, all other anode bits 1. At counter=CLK_DIV-1:
    - counter clears to 0;
    - sel increments, wrapping 7->0;
    - state returns to BLANK.
- frame_tick is 1 for exactly the one cycle in which sel wraps 7->0. It is registered and asserts together with the new sel=0.
- num and seg are registered from the digit at index sel. They update the cycle after sel changes and are always stable before BLANK ends.
- seg encoding (active-low), hex 0-F:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Writes: on wr_en=1, digit[wr_addr] <= wr_data at the clock edge.
  - Accepted in any state and regardless of en.
  - If wr_addr equals the digit being shown, num and seg show the new value one cycle later, mid-slot, with no glitch to other digits.
  - Only one write per cycle; no write collision exists.
- en=0:
  - an forced to 8'hFF on the next edge; counter, state and sel hold.
  - frame_tick stays 0.
  - When en returns to 1, the scan resumes from the held counter and state.
- Reset mid-slot: all outputs return to reset values immediately, independent of clk. After release, scanning restarts at sel=0, BLANK.
- Counter width is $clog2(CLK_DIV); no overflow beyond CLK_DIV-1.

Decomposition:
- Package seg7_pkg:
  - segment pattern lookup constant (16x7, active-low);
  - localparam DIGIT_W=4, SEL_W=3;
  - enum scan_state_t {BLANK, SHOW}.
- Sub-module seg7_hex_decode: combinational 4-bit to 7-segment decoder, instantiated once. seg is registered in seg7_scan_ctrl.

Test Plan (CLK_DIV=8, BLANK_CYCLES=2):
- Reset check: hold rst_n=0, toggle clk -> an=FF, seg=7F, sel=0, frame_tick=0. Assert rst_n mid-SHOW -> same values immediately, asynchronous to clk.
- Full scan: write digits 0..7 with 1,2,3,4,5,6,7,8; en=1.
  - Each slot shows an=FF for 2 cycles, then an[sel]=0 for 6 cycles.
  - seg matches the table (digit 0 -> 79, digit 7 -> 00).
  - frame_tick pulses once every 64 cycles.
- Wrap: run two frames -> sel sequence 0..7,0. frame_tick coincides with sel becoming 0 and never appears elsewhere.
- Live write: while sel=3 in SHOW, write addr 3 = A -> seg=08 one cycle later; an stays F7; neighbouring digits are unchanged on the next visit.
- Enable gating: drop en for 20 cycles mid-SHOW on sel=5 -> an=FF next cycle, sel holds 5. After re-enable, the remaining SHOW cycles complete and then sel=6.
- All-hex sweep: write wr_data 0..F to digit 0 across frames -> seg sequence 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
